// File: rtl/multicycle_controller.sv
// Multicycle control FSM: sequences fetch/decode/memory/execute/write-back, owns the NZCV
// flags and condition check, and stalls execute for MUL/MOD.
module multicycle_controller #(
    parameter int unsigned ALUCTRL_W  = 3,
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           cond,
    input  logic [1:0]           op,
    input  logic [5:0]           funct,
    input  logic [3:0]           rd,
    input  logic [3:0]           alu_flags,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 adr_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           result_src,
    output logic [1:0]           imm_src,
    output logic [1:0]           reg_src,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [3:0]           flags,
    output logic                 busy_exec,
    output logic                 illegal
);

    localparam int unsigned CntW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
        StExecR, StExecI, StAluWb, StBranch, StIllegal
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      flags_q;
    logic            illegal_q;

    logic [2:0] alu_op;
    logic       cmd_valid, is_muldiv, is_arith, cond_ex, exec_last, in_exec;

    always_comb begin
        alu_op    = 3'd0;
        cmd_valid = 1'b1;
        is_muldiv = 1'b0;
        is_arith  = 1'b0;
        case (funct[4:1])
            4'b0100: begin alu_op = 3'd0; is_arith = 1'b1; end
            4'b0010: begin alu_op = 3'd1; is_arith = 1'b1; end
            4'b0111: begin alu_op = 3'd2; is_muldiv = 1'b1; end
            4'b1001: begin alu_op = 3'd3; is_muldiv = 1'b1; end
            4'b0000: alu_op = 3'd4;
            default: cmd_valid = 1'b0;
        endcase
    end

    // Condition check always sees the registered (pre-update) flags.
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags_q;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = !z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = !c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = !n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = !v;
            4'b1000: cond_ex = c && !z;
            4'b1001: cond_ex = !c || z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = !z && (n == v);
            4'b1101: cond_ex = z || (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign in_exec   = (state_q == StExecR) || (state_q == StExecI);
    assign exec_last = !is_muldiv || (cnt_q == CntW'(MULDIV_LAT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StFetch;
            cnt_q     <= '0;
            flags_q   <= 4'b0000;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                StFetch:  state_q <= StDecode;
                StDecode: begin
                    cnt_q <= '0;
                    case (op)
                        2'b01: state_q <= StMemAdr;
                        2'b10: state_q <= StBranch;
                        2'b00: begin
                            if (!cmd_valid) begin
                                state_q   <= StIllegal;
                                illegal_q <= 1'b1;
                            end else begin
                                state_q <= funct[5] ? StExecI : StExecR;
                            end
                        end
                        default: begin
                            state_q   <= StIllegal;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                StMemAdr: state_q <= funct[0] ? StMemRd : StMemWr;
                StMemRd:  state_q <= StMemWb;
                StExecR, StExecI: begin
                    if (exec_last) begin
                        if (funct[0] && cond_ex) begin
                            flags_q[3:2] <= alu_flags[3:2];
                            if (is_arith) flags_q[1:0] <= alu_flags[1:0];
                        end
                        state_q <= StAluWb;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StIllegal: state_q <= StIllegal;
                default:   state_q <= StFetch;
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        imm_src     = 2'b00;
        reg_src     = 2'b00;
        alu_control = '0;
        if (state_q != StFetch && state_q != StIllegal) begin
            imm_src = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
            reg_src = (op == 2'b01 && !funct[0]) ? 2'b10 : (op == 2'b10) ? 2'b01 : 2'b00;
        end
        case (state_q)
            StFetch: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            StDecode: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            StMemAdr: alu_src_b = 2'b01;
            StMemRd:  adr_src = 1'b1;
            StMemWb: begin
                result_src = 2'b01;
                reg_write  = cond_ex;
                pc_write   = cond_ex && (rd == 4'hF);
            end
            StMemWr: begin
                adr_src   = 1'b1;
                mem_write = cond_ex;
            end
            StExecR, StExecI: begin
                alu_src_b   = (state_q == StExecI) ? 2'b01 : 2'b00;
                alu_control = ALUCTRL_W'(alu_op);
            end
            StAluWb: begin
                reg_write = cond_ex;
                pc_write  = cond_ex && (rd == 4'hF);
            end
            StBranch: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = cond_ex;
            end
            default: ;
        endcase
        // Reset overrides every write enable, even mid-instruction.
        if (!reset_n) begin
            pc_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
        end
    end

    assign busy_exec = in_exec && !exec_last;
    assign flags     = flags_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks ADD, SUBS/BEQ, LDR, MULS, ADDS, STR with reset,
// and an illegal opcode, checking enables, selects and flags cycle by cycle.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] cond, rd, alu_flags;
    logic [1:0] op;
    logic [5:0] funct;
    logic       pc_write, reg_write, mem_write, ir_write, adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src, imm_src, reg_src;
    logic [2:0] alu_control;
    logic [3:0] flags;
    logic       busy_exec, illegal;
    logic [3:0] en;

    int checks = 0;
    int errors = 0;

    multicycle_controller #(.ALUCTRL_W(3), .MULDIV_LAT(4)) dut (
        .clk(clk), .reset_n(reset_n), .cond(cond), .op(op), .funct(funct), .rd(rd),
        .alu_flags(alu_flags), .pc_write(pc_write), .reg_write(reg_write),
        .mem_write(mem_write), .ir_write(ir_write), .adr_src(adr_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src), .reg_src(reg_src),
        .alu_control(alu_control), .flags(flags), .busy_exec(busy_exec), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign en = {pc_write, reg_write, mem_write, ir_write};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; cond = 4'hE; op = 2'b00; funct = 6'b0; rd = 4'h1; alu_flags = 4'h0;
        step();
        chk("rst_en", en, 4'b0000);
        reset_n = 1'b1;
        #1;
        chk("rst_fetch_en", en, 4'b1001);
        chk("rst_flags", flags, 4'b0000);
        chk("rst_illegal", illegal, 1'b0);

        // ADD r1
        funct = 6'b001000;
        chk("add_fetch_srcb", alu_src_b, 2'b10);
        step(); chk("add_dec_en", en, 4'b0000);
        chk("add_dec_srca", alu_src_a, 1'b1);
        step(); chk("add_ex_en", en, 4'b0000);
        chk("add_ex_aluc", alu_control, 3'd0);
        chk("add_ex_srcb", alu_src_b, 2'b00);
        step(); chk("add_wb_en", en, 4'b0100);
        chk("add_wb_res", result_src, 2'b00);
        step(); chk("add_next_fetch", en, 4'b1001);

        // SUBS with alu_flags 0110
        funct = 6'b000101; alu_flags = 4'b0110;
        step(); step();
        chk("subs_aluc", alu_control, 3'd1);
        chk("subs_flags_pre", flags, 4'b0000);
        step(); chk("subs_flags_post", flags, 4'b0110);
        chk("subs_wb_en", en, 4'b0100);
        step(); chk("subs_next_fetch", en, 4'b1001);

        // BEQ, Z=1
        op = 2'b10; cond = 4'b0000; funct = 6'b000000; alu_flags = 4'b0000;
        step(); chk("beq_dec_en", en, 4'b0000);
        step(); chk("beq_br_en", en, 4'b1000);
        chk("beq_imm", imm_src, 2'b10);
        chk("beq_regsrc", reg_src, 2'b01);
        chk("beq_srcb", alu_src_b, 2'b01);
        step(); chk("beq_next_fetch", en, 4'b1001);

        // LDR pc with NE while Z=1: suppressed
        op = 2'b01; funct = 6'b011001; cond = 4'b0001; rd = 4'hF;
        step();
        step(); chk("ldr_adr_srcb", alu_src_b, 2'b01);
        chk("ldr_adr_imm", imm_src, 2'b01);
        step(); chk("ldr_rd_adr", adr_src, 1'b1);
        chk("ldr_rd_en", en, 4'b0000);
        step(); chk("ldr_wb_en", en, 4'b0000);
        chk("ldr_wb_res", result_src, 2'b01);
        step(); chk("ldr_next_fetch", en, 4'b1001);

        // MULS: 4 execute cycles, N,Z updated only
        op = 2'b00; funct = 6'b010011; cond = 4'hE; rd = 4'h2; alu_flags = 4'b1001;
        step(); step();
        chk("mul_ex1_busy", busy_exec, 1'b1);
        chk("mul_aluc", alu_control, 3'd3);
        step(); chk("mul_ex2_busy", busy_exec, 1'b1);
        step(); chk("mul_ex3_busy", busy_exec, 1'b1);
        step(); chk("mul_ex4_busy", busy_exec, 1'b0);
        chk("mul_ex4_en", en, 4'b0000);
        chk("mul_flags_pre", flags, 4'b0110);
        step(); chk("mul_wb_en", en, 4'b0100);
        chk("mul_flags_post", flags, 4'b1010);
        step(); chk("mul_next_fetch", en, 4'b1001);

        // ADDS with EQ while Z=0: no flag update, no write
        funct = 6'b001001; cond = 4'b0000; alu_flags = 4'b1111;
        step(); step(); step();
        chk("adds_nc_flags", flags, 4'b1010);
        chk("adds_nc_wb_en", en, 4'b0000);
        step(); chk("adds_nc_fetch", en, 4'b1001);

        // STR interrupted by reset during MEMWR
        op = 2'b01; funct = 6'b011000; cond = 4'hE;
        step(); chk("str_dec_regsrc", reg_src, 2'b10);
        step(); step();
        chk("str_wr_en", en, 4'b0010);
        reset_n = 1'b0;
        #1; chk("str_rst_en", en, 4'b0000);
        step(); reset_n = 1'b1;
        #1; chk("str_rst_fetch", en, 4'b1001);
        chk("str_rst_flags", flags, 4'b0000);

        // Illegal opcode, then reset recovery
        op = 2'b11; funct = 6'b000000;
        step(); chk("ill_dec_flag", illegal, 1'b0);
        step(); chk("ill_flag", illegal, 1'b1);
        chk("ill_en", en, 4'b0000);
        step(); chk("ill_sticky", illegal, 1'b1);
        chk("ill_sticky_en", en, 4'b0000);
        reset_n = 1'b0;
        step(); reset_n = 1'b1;
        #1; chk("ill_rst_flag", illegal, 1'b0);
        chk("ill_rst_fetch", en, 4'b1001);
        chk("ill_rst_flags", flags, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
